bcd_down_timer: RTL and testbench

Cascadable multi-digit BCD down-counter with load, run/pause and a terminal-count pulse. It is the decrementing counterpart to the team's mod-10 up-counter. Counting starts from a loaded BCD value and advances by one on each qualified tick. On reaching zero it raises a one-cycle DONE pulse and holds there. It sits between the seconds-tick divider and the 7-segment display path, as the countdown/timer engine.

---
 rtl/bcd_down_timer_if.sv | 41 ++++
 rtl/bcd_down_timer.sv | 118 +++++++++++
 tb/tb_bcd_down_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for bcd_down_timer: load/run/tick commands in,
// registered BCD count and status flags out.
interface bcd_down_timer_if #(
   parameter int DIGITS = 2
);
   localparam int W = 4 * DIGITS;

   logic         load;
   logic [W-1:0] ldval;
   logic         run;
   logic         tick;
   logic [W-1:0] cnt;
   logic         zero;
   logic         busy;
   logic         done;

   // Handshake: there is no valid/ready pair. Every input is sampled on each
   // rising clock edge. load and tick are single-cycle strobes and run is a level.
   // The timer always accepts them, subject to its priority rules.
   modport master (
      output load,
      output ldval,
      output run,
      output tick,
      input  cnt,
      input  zero,
      input  busy,
      input  done
   );

   modport slave (
      input  load,
      input  ldval,
      input  run,
      input  tick,
      output cnt,
      output zero,
      output busy,
      output done
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Cascadable multi-digit BCD down-counter: load, run/pause, one-cycle DONE on
// reaching zero by counting, then holds in EXPIRED until reloaded or reset.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   bcd_down_timer_if.slave   bus,
   output logic [1:0]        o_state
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic         r_busy;

   logic [W-1:0]      w_ldval_clamped;
   logic [W-1:0]      w_cnt_dec;
   logic [DIGITS-1:0] w_borrow;
   logic              w_zero;
   logic              w_is_one;

   // Per-digit clamping of the load value and the BCD borrow chain.
   // w_borrow[i] is the borrow that flows into digit i. Digit 0 always takes
   // the decrement. A borrow continues upward only past digits that read 0.
   // No borrow leaves the top digit, because COUNT never holds a zero count.
   assign w_borrow[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_ld_dig;
      logic [3:0] w_cur_dig;

      assign w_ld_dig  = bus.ldval[4*i +: 4];
      assign w_cur_dig = r_cnt[4*i +: 4];

      assign w_ldval_clamped[4*i +: 4] = (w_ld_dig > 4'd9) ? 4'd9 : w_ld_dig;

      assign w_cnt_dec[4*i +: 4] = !w_borrow[i]        ? w_cur_dig :
                                   (w_cur_dig == 4'd0) ? 4'd9      :
                                                         w_cur_dig - 4'd1;

      if (i < DIGITS - 1) begin : g_chain
         assign w_borrow[i+1] = w_borrow[i] && (w_cur_dig == 4'd0);
      end
   end

   assign w_zero   = (r_cnt == '0);
   assign w_is_one = (r_cnt == W'(1));

   // Next-state and next-count logic. LOAD overrides everything except reset.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;

      if (bus.load) begin
         w_cnt_nxt   = w_ldval_clamped;
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.run && !w_zero) begin
                  w_state_nxt = COUNT;
               end
            end
            COUNT: begin
               if (!bus.run) begin
                  w_state_nxt = IDLE;
               end else if (bus.tick) begin
                  w_cnt_nxt = w_cnt_dec;
                  if (w_is_one) begin
                     w_state_nxt = EXPIRED;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
            EXPIRED: begin
               w_state_nxt = EXPIRED;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= (w_state_nxt == COUNT);
      end
   end

   assign bus.cnt  = r_cnt;
   assign bus.zero = w_zero;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign o_state  = r_state;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: a 2-digit instance carries most steps and
// a 4-digit instance covers the wide borrow chain and wide clamping.
module tb_bcd_down_timer;

   logic clk;
   logic rst;
   logic [1:0] state_a;
   logic [1:0] state_b;

   int n_pass;
   int n_total;

   bcd_down_timer_if #(.DIGITS(2)) bus_a ();
   bcd_down_timer_if #(.DIGITS(4)) bus_b ();

   bcd_down_timer #(.DIGITS(2)) dut_a (
      .i_clk   (clk),
      .i_rst   (rst),
      .bus     (bus_a.slave),
      .o_state (state_a)
   );

   bcd_down_timer #(.DIGITS(4)) dut_b (
      .i_clk   (clk),
      .i_rst   (rst),
      .bus     (bus_b.slave),
      .o_state (state_b)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 ns after the rising edge, and inputs change there too.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_a(input string tag, input logic [7:0] cnt, input logic zero,
                        input logic busy, input logic done, input logic [1:0] st);
      chk({tag, ".cnt"},   {8'h00, bus_a.cnt}, {8'h00, cnt});
      chk({tag, ".zero"},  {15'h0, bus_a.zero}, {15'h0, zero});
      chk({tag, ".busy"},  {15'h0, bus_a.busy}, {15'h0, busy});
      chk({tag, ".done"},  {15'h0, bus_a.done}, {15'h0, done});
      chk({tag, ".state"}, {14'h0, state_a}, {14'h0, st});
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   initial begin
      n_pass  = 0;
      n_total = 0;

      // reset with RUN and TICK high; held for two edges
      rst = 1'b1;
      bus_a.load = 1'b0; bus_a.ldval = 8'h00;  bus_a.run = 1'b1; bus_a.tick = 1'b1;
      bus_b.load = 1'b0; bus_b.ldval = 16'h0;  bus_b.run = 1'b0; bus_b.tick = 1'b0;
      cyc();
      chk_a("reset1", 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      cyc();
      chk_a("reset2", 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;

      // full countdown from 12
      bus_a.run = 1'b0; bus_a.tick = 1'b0;
      bus_a.load = 1'b1; bus_a.ldval = 8'h12;
      cyc();
      chk_a("load12", 8'h12, 1'b0, 1'b0, 1'b0, 2'd0);
      bus_a.load = 1'b0; bus_a.run = 1'b1;
      cyc();
      chk_a("run12", 8'h12, 1'b0, 1'b1, 1'b0, 2'd1);
      bus_a.tick = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk_a($sformatf("down%0d", k), to_bcd(12 - k), (k == 12), (k < 12), (k == 12),
               (k == 12) ? 2'd2 : 2'd1);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_a($sformatf("expired%0d", k), 8'h00, 1'b1, 1'b0, 1'b0, 2'd2);
      end

      // borrow 40 -> 39
      bus_a.tick = 1'b0; bus_a.load = 1'b1; bus_a.ldval = 8'h40;
      cyc();
      chk_a("load40", 8'h40, 1'b0, 1'b0, 1'b0, 2'd0);
      bus_a.load = 1'b0;
      cyc();
      chk_a("run40", 8'h40, 1'b0, 1'b1, 1'b0, 2'd1);
      bus_a.tick = 1'b1;
      cyc();
      chk_a("dec40", 8'h39, 1'b0, 1'b1, 1'b0, 2'd1);

      // borrow 10 -> 09
      bus_a.tick = 1'b0; bus_a.load = 1'b1; bus_a.ldval = 8'h10;
      cyc();
      bus_a.load = 1'b0;
      cyc();
      bus_a.tick = 1'b1;
      cyc();
      chk_a("dec10", 8'h09, 1'b0, 1'b1, 1'b0, 2'd1);

      // pause/resume at 07
      bus_a.tick = 1'b0; bus_a.load = 1'b1; bus_a.ldval = 8'h08;
      cyc();
      bus_a.load = 1'b0;
      cyc();
      bus_a.tick = 1'b1;
      cyc();
      chk_a("dec08", 8'h07, 1'b0, 1'b1, 1'b0, 2'd1);
      bus_a.run = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk_a($sformatf("pause%0d", k), 8'h07, 1'b0, 1'b0, 1'b0, 2'd0);
      end
      bus_a.run = 1'b1; bus_a.tick = 1'b0;
      cyc();
      chk_a("resume", 8'h07, 1'b0, 1'b1, 1'b0, 2'd1);
      bus_a.tick = 1'b1;
      cyc();
      chk_a("dec07", 8'h06, 1'b0, 1'b1, 1'b0, 2'd1);

      // LOAD with coincident TICK during COUNT
      bus_a.load = 1'b1; bus_a.ldval = 8'h55;
      cyc();
      chk_a("load_tick", 8'h55, 1'b0, 1'b0, 1'b0, 2'd0);

      // clamp of non-BCD digits
      bus_a.tick = 1'b0; bus_a.ldval = 8'hAF;
      cyc();
      chk_a("clampAF", 8'h99, 1'b0, 1'b0, 1'b0, 2'd0);

      // LOAD 00 then RUN: stays IDLE, never DONE
      bus_a.ldval = 8'h00;
      cyc();
      chk_a("load00", 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      bus_a.load = 1'b0; bus_a.tick = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_a($sformatf("zero_run%0d", k), 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      end

      // reset mid-count at 05, then 02 -> 00 with a single DONE
      bus_a.tick = 1'b0; bus_a.load = 1'b1; bus_a.ldval = 8'h05;
      cyc();
      bus_a.load = 1'b0;
      cyc();
      chk_a("run05", 8'h05, 1'b0, 1'b1, 1'b0, 2'd1);
      rst = 1'b1;
      cyc();
      chk_a("midrst", 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      rst = 1'b0; bus_a.run = 1'b0;
      cyc();
      chk_a("post_rst", 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
      bus_a.load = 1'b1; bus_a.ldval = 8'h02;
      cyc();
      bus_a.load = 1'b0; bus_a.run = 1'b1;
      cyc();
      chk_a("run02", 8'h02, 1'b0, 1'b1, 1'b0, 2'd1);
      bus_a.tick = 1'b1;
      cyc();
      chk_a("dec02", 8'h01, 1'b0, 1'b1, 1'b0, 2'd1);
      cyc();
      chk_a("dec01", 8'h00, 1'b1, 1'b0, 1'b1, 2'd2);
      cyc();
      chk_a("after_done", 8'h00, 1'b1, 1'b0, 1'b0, 2'd2);
      bus_a.tick = 1'b0; bus_a.run = 1'b0;

      // 4-digit instance: 1000 -> 0999, and clamp F9A3 -> 9993
      chk("b.reset_cnt", bus_b.cnt, 16'h0000);
      bus_b.load = 1'b1; bus_b.ldval = 16'h1000; bus_b.run = 1'b1;
      cyc();
      chk("b.load1000", bus_b.cnt, 16'h1000);
      bus_b.load = 1'b0;
      cyc();
      chk("b.busy", {15'h0, bus_b.busy}, 16'h0001);
      bus_b.tick = 1'b1;
      cyc();
      chk("b.dec1000", bus_b.cnt, 16'h0999);
      cyc();
      chk("b.dec0999", bus_b.cnt, 16'h0998);
      bus_b.tick = 1'b0; bus_b.load = 1'b1; bus_b.ldval = 16'hF9A3;
      cyc();
      chk("b.clamp", bus_b.cnt, 16'h9993);
      chk("b.state", {14'h0, state_b}, 16'h0000);
      bus_b.load = 1'b0; bus_b.run = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
